// File: rtl/r_cpu_pkg.sv
// r_cpu_pkg
// Shared definitions for the R_CPU R-type execution path:
//   - controller FSM state encoding
//   - MIPS R-format funct codes handled by the controller
//   - 5-bit ALU operation codes (bit 4 is always 0), shared with ALU users
//   - decode_funct(): maps funct to {legal, operand swap, ALU op}
package r_cpu_pkg;

  localparam int NREG = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_EXEC,
    ST_WB
  } state_e;

  localparam logic [5:0] FUNCT_SLLV = 6'h04;
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_XOR  = 6'h26;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLTU = 6'h2B;

  localparam logic [4:0] ALU_AND  = 5'b00000;
  localparam logic [4:0] ALU_OR   = 5'b00001;
  localparam logic [4:0] ALU_XOR  = 5'b00010;
  localparam logic [4:0] ALU_NOR  = 5'b00011;
  localparam logic [4:0] ALU_ADD  = 5'b00100;
  localparam logic [4:0] ALU_SUB  = 5'b00101;
  localparam logic [4:0] ALU_SLTU = 5'b00110;
  localparam logic [4:0] ALU_SLLV = 5'b00111;
  localparam logic [4:0] ALU_ADDU = 5'b01000;

  typedef struct packed {
    logic       legal;
    logic       swap;   // SLLV shifts rt by rs, so the ALU sees A=rt, B=rs
    logic [4:0] op;
  } dec_t;

  function automatic dec_t decode_funct(input logic [5:0] funct);
    dec_t d;
    d.legal = 1'b1;
    d.swap  = 1'b0;
    d.op    = ALU_AND;
    case (funct)
      FUNCT_AND:  d.op = ALU_AND;
      FUNCT_OR:   d.op = ALU_OR;
      FUNCT_XOR:  d.op = ALU_XOR;
      FUNCT_NOR:  d.op = ALU_NOR;
      FUNCT_ADD:  d.op = ALU_ADD;
      FUNCT_SUB:  d.op = ALU_SUB;
      FUNCT_SLTU: d.op = ALU_SLTU;
      FUNCT_ADDU: d.op = ALU_ADDU;
      FUNCT_SLLV: begin
        d.op   = ALU_SLLV;
        d.swap = 1'b1;
      end
      default:    d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/r_regfile.sv
// r_regfile
// 32x32 register file for the R_CPU controller.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset (clears all registers)
//   ra1_i/rd1_o, ra2_i/rd2_o two combinational read ports
//   dbgRaddr_i/dbgRdata_o   combinational debug read port
//   we_i, waddr_i, wdata_i  synchronous write port; writes to r0 are dropped
// r0 always reads 0.
module r_regfile
  import r_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ra1_i,
  output logic [31:0] rd1_o,
  input  logic [4:0]  ra2_i,
  output logic [31:0] rd2_o,
  input  logic [4:0]  dbgRaddr_i,
  output logic [31:0] dbgRdata_o,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i
);

  logic [31:0] regs_q [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rd1_o      = (ra1_i      == 5'd0) ? 32'd0 : regs_q[ra1_i];
  assign rd2_o      = (ra2_i      == 5'd0) ? 32'd0 : regs_q[ra2_i];
  assign dbgRdata_o = (dbgRaddr_i == 5'd0) ? 32'd0 : regs_q[dbgRaddr_i];

endmodule

// File: rtl/r_exec_ctrl.sv
// r_exec_ctrl
// Multi-cycle R-type execution controller. Accepts one MIPS R-format
// instruction per handshake, reads rs/rt from the internal register file,
// drives an external combinational ALU, captures its result and writes rd.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   inst_valid/inst_ready, inst    instruction handshake (ready only in IDLE)
//   alu_a, alu_b, alu_op           registered ALU operands and op code
//   alu_f, alu_zf, alu_of          ALU result and flags
//   done, illegal                  retire pulse; illegal marks a skipped instruction
//   zf, of                         sticky flags of the last legal instruction
//   dbg_we/dbg_waddr/dbg_wdata     debug preload (IDLE with inst_valid low only)
//   dbg_raddr/dbg_rdata            combinational debug read
module r_exec_ctrl
  import r_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_valid,
  output logic        inst_ready,
  input  logic [31:0] inst,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_op,
  input  logic [31:0] alu_f,
  input  logic        alu_zf,
  input  logic        alu_of,
  output logic        done,
  output logic        illegal,
  output logic        zf,
  output logic        of,
  input  logic        dbg_we,
  input  logic [4:0]  dbg_waddr,
  input  logic [31:0] dbg_wdata,
  input  logic [4:0]  dbg_raddr,
  output logic [31:0] dbg_rdata
);

  state_e      state_q, state_d;

  logic [5:0]  opcode_q;
  logic [4:0]  rs_q, rt_q, rd_q;
  logic [5:0]  funct_q;
  logic        illegal_q;

  logic [31:0] aluA_q, aluB_q;
  logic [4:0]  aluOp_q;

  logic [31:0] resF_q;
  logic        resZf_q, resOf_q;
  logic        zf_q, of_q;

  logic [31:0] rsData, rtData;
  dec_t        dec;
  logic        decLegal;

  logic        wbWe, dbgWe, rfWe;
  logic [4:0]  rfWaddr;
  logic [31:0] rfWdata;

  assign dec      = decode_funct(funct_q);
  assign decLegal = dec.legal && (opcode_q == 6'd0);

  // ADD/SUB that overflowed must not retire into rd; flags still update.
  assign wbWe  = (state_q == ST_WB) && !illegal_q &&
                 !(((aluOp_q == ALU_ADD) || (aluOp_q == ALU_SUB)) && resOf_q);
  // An offered instruction wins over a debug preload in the same cycle.
  assign dbgWe = (state_q == ST_IDLE) && !inst_valid && dbg_we;

  assign rfWe    = wbWe || dbgWe;
  assign rfWaddr = (state_q == ST_WB) ? rd_q   : dbg_waddr;
  assign rfWdata = (state_q == ST_WB) ? resF_q : dbg_wdata;

  r_regfile u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .ra1_i      (rs_q),
    .rd1_o      (rsData),
    .ra2_i      (rt_q),
    .rd2_o      (rtData),
    .dbgRaddr_i (dbg_raddr),
    .dbgRdata_o (dbg_rdata),
    .we_i       (rfWe),
    .waddr_i    (rfWaddr),
    .wdata_i    (rfWdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (inst_valid) state_d = ST_DECODE;
      ST_DECODE: state_d = decLegal ? ST_EXEC : ST_WB;
      ST_EXEC:   state_d = ST_WB;
      ST_WB:     state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath registers: instruction latch, operand/op registers, ALU result
  // capture and sticky flags, each loaded in the state that owns it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q  <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      funct_q   <= '0;
      illegal_q <= 1'b0;
      aluA_q    <= '0;
      aluB_q    <= '0;
      aluOp_q   <= '0;
      resF_q    <= '0;
      resZf_q   <= 1'b0;
      resOf_q   <= 1'b0;
      zf_q      <= 1'b0;
      of_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (inst_valid) begin
            opcode_q <= inst[31:26];
            rs_q     <= inst[25:21];
            rt_q     <= inst[20:16];
            rd_q     <= inst[15:11];
            funct_q  <= inst[5:0];
          end
        end
        ST_DECODE: begin
          if (decLegal) begin
            aluA_q    <= dec.swap ? rtData : rsData;
            aluB_q    <= dec.swap ? rsData : rtData;
            aluOp_q   <= dec.op;
            illegal_q <= 1'b0;
          end else begin
            illegal_q <= 1'b1;
          end
        end
        ST_EXEC: begin
          resF_q  <= alu_f;
          resZf_q <= alu_zf;
          resOf_q <= alu_of;
        end
        ST_WB: begin
          if (!illegal_q) begin
            zf_q <= resZf_q;
            of_q <= resOf_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign inst_ready = (state_q == ST_IDLE);
  assign done       = (state_q == ST_WB);
  assign illegal    = (state_q == ST_WB) && illegal_q;
  assign alu_a      = aluA_q;
  assign alu_b      = aluB_q;
  assign alu_op     = aluOp_q;
  assign zf         = zf_q;
  assign of         = of_q;

endmodule
